// File: rtl/bus_xfer_engine_if.sv
// Request/response bundle of the register transfer engine plus its debug read port.
// The engine connects through slave; the requester side uses master.
interface bus_xfer_engine_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_mode;
    logic [IDX_W-1:0] req_src;
    logic [IDX_W-1:0] req_dst;
    logic [15:0]      req_imm;
    logic [IDX_W-1:0] rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] bus_data;
    logic             busy;
    logic             done;
    logic             err;
    logic             carry;

    modport slave (
        input  req_valid, req_mode, req_src, req_dst, req_imm, rd_addr,
        output req_ready, rd_data, bus_data, busy, done, err, carry
    );

    modport master (
        output req_valid, req_mode, req_src, req_dst, req_imm, rd_addr,
        input  req_ready, rd_data, bus_data, busy, done, err, carry
    );
endinterface

// File: rtl/bus_xfer_engine.sv
// Register-file transfer engine (MOVE/ADD/SWAP/LDI); done 3 cycles after accept for MOVE/LDI, 4 for ADD/SWAP.
// One request in flight: req_ready only in IDLE; a bad index is consumed with a one-cycle err pulse.
module bus_xfer_engine #(
    parameter int WIDTH   = 32,
    parameter int NREG    = 16,
    parameter int IDX_W   = 5,
    parameter int R0_ZERO = 0
) (
    input  logic                clk,
    input  logic                clr,
    bus_xfer_engine_if.slave    xif
);
    typedef enum logic [1:0] {S_IDLE, S_RD, S_ALU, S_WB} state_e;
    typedef enum logic [1:0] {M_MOVE = 2'b00, M_ADD = 2'b01, M_SWAP = 2'b10, M_LDI = 2'b11} mode_e;

    state_e           state_q, state_d;
    mode_e            mode_q;
    logic [IDX_W-1:0] src_q, dst_q;
    logic [15:0]      imm_q;
    logic [WIDTH-1:0] y_q, y_d, z_q, z_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             rdy_en_q;
    logic [WIDTH-1:0] regs_q [NREG];

    logic             accept, req_bad;
    logic [WIDTH-1:0] bus_dat, imm_ext;
    logic [WIDTH:0]   sum;
    logic             wa_en, wb_en;
    logic [IDX_W-1:0] wa_idx, wb_idx;
    logic [WIDTH-1:0] wa_dat, wb_dat;

    // Register 0 reads as zero when hard-wired; unmatched indices read as zero.
    function automatic logic [WIDTH-1:0] rd_reg(input logic [IDX_W-1:0] idx);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == IDX_W'(i) && !(R0_ZERO != 0 && i == 0)) v = regs_q[i];
        end
        return v;
    endfunction

    function automatic logic in_rng(input logic [IDX_W-1:0] idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (idx == IDX_W'(i)) r = 1'b1;
        end
        return r;
    endfunction

    assign imm_ext = {{(WIDTH-16){imm_q[15]}}, imm_q};
    assign accept  = (state_q == S_IDLE) && rdy_en_q && xif.req_valid;
    assign req_bad = ((mode_e'(xif.req_mode) != M_LDI) && !in_rng(xif.req_src))
                   || !in_rng(xif.req_dst);
    assign sum     = {1'b0, y_q} + {1'b0, bus_dat};

    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        z_d     = z_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        bus_dat = '0;
        wa_en   = 1'b0;
        wa_idx  = dst_q;
        wa_dat  = z_q;
        wb_en   = 1'b0;
        wb_idx  = dst_q;
        wb_dat  = y_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_bad) err_d = 1'b1;
                    else         state_d = S_RD;
                end
            end
            S_RD: begin
                if (mode_q == M_LDI) bus_dat = imm_ext;
                else                 bus_dat = rd_reg(src_q);
                if (mode_q == M_MOVE || mode_q == M_LDI) begin
                    z_d     = bus_dat;
                    state_d = S_WB;
                end else begin
                    y_d     = bus_dat;
                    state_d = S_ALU;
                end
            end
            S_ALU: begin
                bus_dat = rd_reg(dst_q);
                if (mode_q == M_ADD) {carry_d, z_d} = sum;
                else                 z_d = bus_dat;
                state_d = S_WB;
            end
            S_WB: begin
                wa_en   = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
                // SWAP writes both ends on one edge; with src==dst both carry the same value.
                if (mode_q == M_SWAP) begin
                    wa_idx = src_q;
                    wb_en  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            mode_q   <= M_MOVE;
            src_q    <= '0;
            dst_q    <= '0;
            imm_q    <= '0;
            y_q      <= '0;
            z_q      <= '0;
            carry_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdy_en_q <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            z_q      <= z_d;
            carry_q  <= carry_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdy_en_q <= 1'b1;
            if (accept) begin
                mode_q <= mode_e'(xif.req_mode);
                src_q  <= xif.req_src;
                dst_q  <= xif.req_dst;
                imm_q  <= xif.req_imm;
            end
            for (int i = 0; i < NREG; i++) begin
                if (!(R0_ZERO != 0 && i == 0)) begin
                    if (wa_en && wa_idx == IDX_W'(i)) regs_q[i] <= wa_dat;
                    if (wb_en && wb_idx == IDX_W'(i)) regs_q[i] <= wb_dat;
                end
            end
        end
    end

    always_comb begin
        xif.rd_data = rd_reg(xif.rd_addr);
    end

    assign xif.req_ready = (state_q == S_IDLE) && rdy_en_q;
    assign xif.bus_data  = bus_dat;
    assign xif.busy      = (state_q != S_IDLE);
    assign xif.done      = done_q;
    assign xif.err       = err_q;
    assign xif.carry     = carry_q;
endmodule

// File: tb/tb_bus_xfer_engine.sv
// Directed bench: instance A (NREG=12) for transfers, errors and reset; instance B (R0_ZERO=1) for register 0.
module tb_bus_xfer_engine;
    localparam logic [1:0] MOVE = 2'b00, ADD = 2'b01, SWAP = 2'b10, LDI = 2'b11;

    logic        clk, clr;
    logic        valid, sel;
    logic [1:0]  mode;
    logic [4:0]  src, dst, raddr;
    logic [15:0] imm;
    int          n_chk, n_fail;

    bus_xfer_engine_if #(.WIDTH(32), .IDX_W(5)) ifa ();
    bus_xfer_engine_if #(.WIDTH(32), .IDX_W(5)) ifb ();

    assign ifa.req_valid = valid & ~sel;
    assign ifb.req_valid = valid & sel;
    assign ifa.req_mode  = mode;
    assign ifb.req_mode  = mode;
    assign ifa.req_src   = src;
    assign ifb.req_src   = src;
    assign ifa.req_dst   = dst;
    assign ifb.req_dst   = dst;
    assign ifa.req_imm   = imm;
    assign ifb.req_imm   = imm;
    assign ifa.rd_addr   = raddr;
    assign ifb.rd_addr   = raddr;

    bus_xfer_engine #(.WIDTH(32), .NREG(12), .IDX_W(5), .R0_ZERO(0)) dut_a (
        .clk(clk), .clr(clr), .xif(ifa)
    );
    bus_xfer_engine #(.WIDTH(32), .NREG(16), .IDX_W(5), .R0_ZERO(1)) dut_b (
        .clk(clk), .clr(clr), .xif(ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rdreg(input logic [4:0] a, output logic [31:0] v);
        @(negedge clk);
        raddr = a;
        #1;
        v = sel ? ifb.rd_data : ifa.rd_data;
    endtask

    // Presents one request, scrambles the inputs after acceptance, then waits up to 8
    // cycles for done; lat is the cycle count from acceptance (99 when done never came).
    task automatic send(input logic [1:0] m, input logic [4:0] s, input logic [4:0] d,
                        input logic [15:0] im, output int lat, output logic rdy0,
                        output logic [31:0] bus1, output logic err1, output logic rdy1);
        int  i;
        logic seen;
        mode = m; src = s; dst = d; imm = im; valid = 1'b1;
        rdy0 = sel ? ifb.req_ready : ifa.req_ready;
        @(posedge clk);
        #1;
        valid = 1'b0; mode = ~m; src = ~s; dst = ~d; imm = ~im;
        lat = 99; bus1 = '0; err1 = 1'b0; rdy1 = 1'b0; seen = 1'b0; i = 1;
        while (!seen && i <= 8) begin
            @(negedge clk);
            if (i == 1) begin
                bus1 = sel ? ifb.bus_data : ifa.bus_data;
                err1 = sel ? ifb.err : ifa.err;
                rdy1 = sel ? ifb.req_ready : ifa.req_ready;
            end
            if (sel ? ifb.done : ifa.done) begin
                lat  = i;
                seen = 1'b1;
            end
            i++;
        end
    endtask

    initial begin
        int          lat, dcnt;
        logic        rdy0, err1, rdy1;
        logic [31:0] bus1, v;

        n_chk = 0; n_fail = 0;
        valid = 1'b0; sel = 1'b0; mode = 2'b00; src = '0; dst = '0; imm = '0; raddr = '0;
        clr = 1'b1;
        #1 clr = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready", ifa.req_ready, 0);
        check("rst_busy", ifa.busy, 0);
        check("rst_done", ifa.done, 0);
        check("rst_err", ifa.err, 0);
        check("rst_carry", ifa.carry, 0);
        check("rst_bus", ifa.bus_data, 0);
        rdreg(5'd3, v); check("rst_r3", v, 0);
        @(negedge clk);
        clr = 1'b1;
        #1 check("ready_before_edge", ifa.req_ready, 0);
        @(posedge clk); #1;
        check("ready_after_edge", ifa.req_ready, 1);
        @(negedge clk);

        // LDI then MOVE back to back
        send(LDI, 5'd0, 5'd3, 16'hFFFF, lat, rdy0, bus1, err1, rdy1);
        check("ldi_rdy0", rdy0, 1);
        check("ldi_lat", lat, 3);
        check("ldi_bus", bus1, 32'hFFFF_FFFF);
        check("ldi_busy_rdy", rdy1, 0);
        send(MOVE, 5'd3, 5'd5, 16'h0, lat, rdy0, bus1, err1, rdy1);
        check("move_rdy_in_done", rdy0, 1);
        check("move_lat", lat, 3);
        check("move_bus", bus1, 32'hFFFF_FFFF);
        rdreg(5'd5, v); check("move_r5", v, 32'hFFFF_FFFF);
        rdreg(5'd3, v); check("move_r3", v, 32'hFFFF_FFFF);

        // ADD with wrap-around
        send(LDI, 5'd0, 5'd1, 16'hFFFF, lat, rdy0, bus1, err1, rdy1);
        send(LDI, 5'd0, 5'd2, 16'h0002, lat, rdy0, bus1, err1, rdy1);
        rdreg(5'd2, v); check("ldi_pos", v, 32'h0000_0002);
        send(ADD, 5'd1, 5'd2, 16'h0, lat, rdy0, bus1, err1, rdy1);
        check("add_lat", lat, 4);
        rdreg(5'd2, v); check("add_r2", v, 32'h0000_0001);
        check("add_carry", ifa.carry, 1);

        // SWAP
        send(LDI, 5'd0, 5'd4, 16'h0011, lat, rdy0, bus1, err1, rdy1);
        send(LDI, 5'd0, 5'd6, 16'h0022, lat, rdy0, bus1, err1, rdy1);
        check("carry_hold", ifa.carry, 1);
        send(SWAP, 5'd4, 5'd6, 16'h0, lat, rdy0, bus1, err1, rdy1);
        check("swap_lat", lat, 4);
        rdreg(5'd4, v); check("swap_r4", v, 32'h22);
        rdreg(5'd6, v); check("swap_r6", v, 32'h11);
        send(SWAP, 5'd6, 5'd6, 16'h0, lat, rdy0, bus1, err1, rdy1);
        rdreg(5'd6, v); check("swap_same", v, 32'h11);

        // Sign extension and ADD src==dst
        send(LDI, 5'd0, 5'd7, 16'h8000, lat, rdy0, bus1, err1, rdy1);
        rdreg(5'd7, v); check("ldi_neg", v, 32'hFFFF_8000);
        send(LDI, 5'd0, 5'd7, 16'h0005, lat, rdy0, bus1, err1, rdy1);
        send(ADD, 5'd7, 5'd7, 16'h0, lat, rdy0, bus1, err1, rdy1);
        rdreg(5'd7, v); check("add_double", v, 32'h0000_000A);
        check("add_nocarry", ifa.carry, 0);

        // LDI ignores src range
        send(LDI, 5'd31, 5'd8, 16'h0042, lat, rdy0, bus1, err1, rdy1);
        check("ldi_src_err", err1, 0);
        check("ldi_src_lat", lat, 3);
        rdreg(5'd8, v); check("ldi_src_r8", v, 32'h42);

        // Rejected requests
        send(MOVE, 5'd13, 5'd1, 16'h0, lat, rdy0, bus1, err1, rdy1);
        check("err_src_pulse", err1, 1);
        check("err_src_ready", rdy1, 1);
        check("err_src_nodone", lat, 99);
        check("err_src_clear", ifa.err, 0);
        rdreg(5'd1, v); check("err_src_r1", v, 32'hFFFF_FFFF);
        send(LDI, 5'd0, 5'd12, 16'h1234, lat, rdy0, bus1, err1, rdy1);
        check("err_dst_pulse", err1, 1);
        rdreg(5'd2, v); check("err_dst_r2", v, 32'h0000_0001);

        // Reset during the ALU cycle of an ADD
        @(negedge clk);
        mode = ADD; src = 5'd1; dst = 5'd2; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midadd_busy", ifa.busy, 1);
        clr = 1'b0;
        #1;
        check("midrst_busy", ifa.busy, 0);
        check("midrst_ready", ifa.req_ready, 0);
        check("midrst_done", ifa.done, 0);
        rdreg(5'd1, v); check("midrst_r1", v, 0);
        rdreg(5'd2, v); check("midrst_r2", v, 0);
        rdreg(5'd4, v); check("midrst_r4", v, 0);
        @(negedge clk);
        clr = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ifa.done) dcnt++;
        end
        check("midrst_nodone", dcnt, 0);

        // Hard-wired register 0 on instance B
        sel = 1'b1;
        @(negedge clk);
        send(LDI, 5'd0, 5'd0, 16'h1234, lat, rdy0, bus1, err1, rdy1);
        check("r0_lat", lat, 3);
        check("r0_bus", bus1, 32'h0000_1234);
        rdreg(5'd0, v); check("r0_read", v, 0);
        send(LDI, 5'd0, 5'd9, 16'h7777, lat, rdy0, bus1, err1, rdy1);
        rdreg(5'd9, v); check("r9_ldi", v, 32'h7777);
        send(MOVE, 5'd0, 5'd9, 16'h0, lat, rdy0, bus1, err1, rdy1);
        check("r0_move_bus", bus1, 0);
        rdreg(5'd9, v); check("r0_move_r9", v, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
